// File: rtl/multicycle_fsm.sv
// Multicycle MIPS-subset control unit.
// Sequences the datapath through fetch, decode and per-class execute states,
// emitting write enables and mux selects each cycle, flagging unsupported
// instructions (sticky) and counting retired instructions.
module multicycle_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_we,
    output logic        ir_we,
    output logic        mem_we,
    output logic        reg_we,
    output logic        a_we,
    output logic        b_we,
    output logic        mem_in,
    output logic [1:0]  reg_dst,
    output logic [1:0]  reg_in,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        zext,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        R_WB     = 4'd7,
        EXEC_I   = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        JAL      = 4'd12,
        JR       = 4'd13,
        HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    state_t cur_state;
    state_t nxt_state;
    logic   illegal_set;

    assign state = cur_state;

    // State register: reset returns to FETCH from anywhere, including HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and control outputs; everything is held at 0 while reset is high.
    always_comb begin
        nxt_state   = cur_state;
        illegal_set = 1'b0;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        mem_we      = 1'b0;
        reg_we      = 1'b0;
        a_we        = 1'b0;
        b_we        = 1'b0;
        mem_in      = 1'b0;
        reg_dst     = 2'd0;
        reg_in      = 2'd0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        zext        = 1'b0;
        alu_op      = ALU_ADD;
        pc_src      = 2'd0;
        instr_done  = 1'b0;
        if (!reset) begin
            case (cur_state)
                FETCH: begin
                    ir_we     = 1'b1;
                    alu_src_b = 2'd2;
                    pc_we     = 1'b1;
                    nxt_state = DECODE;
                end
                DECODE: begin
                    a_we      = 1'b1;
                    b_we      = 1'b1;
                    alu_src_b = 2'd3;
                    case (opcode)
                        OP_RTYPE: begin
                            case (funct)
                                FN_ADD, FN_SUB, FN_SLT: nxt_state = EXEC_R;
                                FN_JR:                  nxt_state = JR;
                                default: begin
                                    nxt_state   = HALT;
                                    illegal_set = 1'b1;
                                end
                            endcase
                        end
                        OP_LW, OP_SW:     nxt_state = MEM_ADDR;
                        OP_ADDI, OP_XORI: nxt_state = EXEC_I;
                        OP_BEQ, OP_BNE:   nxt_state = BRANCH;
                        OP_J:             nxt_state = JUMP;
                        OP_JAL:           nxt_state = JAL;
                        default: begin
                            nxt_state   = HALT;
                            illegal_set = 1'b1;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd1;
                    nxt_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
                end
                MEM_RD: begin
                    mem_in    = 1'b1;
                    nxt_state = MEM_WB;
                end
                MEM_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = 2'd1;
                    reg_in     = 2'd1;
                    instr_done = 1'b1;
                    nxt_state  = FETCH;
                end
                MEM_WR: begin
                    mem_in     = 1'b1;
                    mem_we     = 1'b1;
                    instr_done = 1'b1;
                    nxt_state  = FETCH;
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    case (funct)
                        FN_SUB:  alu_op = ALU_SUB;
                        FN_SLT:  alu_op = ALU_SLT;
                        default: alu_op = ALU_ADD;
                    endcase
                    nxt_state = R_WB;
                end
                R_WB: begin
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                    nxt_state  = FETCH;
                end
                EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd1;
                    if (opcode == OP_XORI) begin
                        alu_op = ALU_XOR;
                        zext   = 1'b1;
                    end
                    nxt_state = I_WB;
                end
                I_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = 2'd1;
                    instr_done = 1'b1;
                    nxt_state  = FETCH;
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_SUB;
                    pc_src     = 2'd1;
                    pc_we      = (opcode == OP_BNE) ? ~zero : zero;
                    instr_done = 1'b1;
                    nxt_state  = FETCH;
                end
                JUMP: begin
                    pc_src     = 2'd2;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    nxt_state  = FETCH;
                end
                JAL: begin
                    pc_src     = 2'd2;
                    pc_we      = 1'b1;
                    reg_we     = 1'b1;
                    reg_dst    = 2'd2;
                    reg_in     = 2'd2;
                    instr_done = 1'b1;
                    nxt_state  = FETCH;
                end
                JR: begin
                    pc_src     = 2'd3;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    nxt_state  = FETCH;
                end
                HALT: begin
                    nxt_state = HALT;
                end
                default: begin
                    nxt_state = FETCH;
                end
            endcase
        end
    end

    // Sticky illegal-instruction flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal <= 1'b0;
        end else if (illegal_set) begin
            illegal <= 1'b1;
        end
    end

    // Retired-instruction counter; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count <= '0;
        end else if (instr_done) begin
            instr_count <= instr_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_multicycle_fsm.sv
// Bench for multicycle_fsm: a per-cycle vector table for the full control
// word, a hand-written HALT/reset sequence, and randomized instruction
// streams checked against an instruction-level effect model.
module tb_multicycle_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        pc_we, ir_we, mem_we, reg_we, a_we, b_we, mem_in;
    logic [1:0]  reg_dst, reg_in, alu_src_b, pc_src;
    logic        alu_src_a, zext, instr_done, illegal;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic [31:0] instr_count;

    multicycle_fsm u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_we(pc_we), .ir_we(ir_we), .mem_we(mem_we), .reg_we(reg_we),
        .a_we(a_we), .b_we(b_we), .mem_in(mem_in), .reg_dst(reg_dst),
        .reg_in(reg_in), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .zext(zext), .alu_op(alu_op), .pc_src(pc_src), .state(state),
        .instr_done(instr_done), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int unsigned nvec = 0;
    int unsigned nmis = 0;

    logic [24:0] act_word;
    assign act_word = {state, pc_we, ir_we, mem_we, reg_we, a_we, b_we, mem_in,
                       reg_dst, reg_in, alu_src_a, alu_src_b, zext, alu_op,
                       pc_src, instr_done};

    logic [8:0] act_fx;
    assign act_fx = {state, instr_done, pc_we, ir_we, mem_we, reg_we};

    function automatic logic [24:0] cw(int st, int pcwe, int irwe, int memwe,
                                       int regwe, int awe, int bwe, int memin,
                                       int rdst, int rin, int asa, int asb,
                                       int zx, int aop, int psrc, int done);
        return {4'(st), 1'(pcwe), 1'(irwe), 1'(memwe), 1'(regwe), 1'(awe),
                1'(bwe), 1'(memin), 2'(rdst), 2'(rin), 1'(asa), 2'(asb),
                1'(zx), 3'(aop), 2'(psrc), 1'(done)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    typedef struct {
        string       nm;
        logic        r;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [24:0] ew;
        logic        ill;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(string nm, int r, int op, int fn, int z,
                                logic [24:0] ew, int ill, int cnt);
        vec_t v;
        v.nm = nm; v.r = 1'(r); v.op = 6'(op); v.fn = 6'(fn); v.z = 1'(z);
        v.ew = ew; v.ill = 1'(ill); v.cnt = 32'(cnt);
        tbl.push_back(v);
    endfunction

    // One clock cycle: drive just after the rising edge, check at the falling edge.
    task automatic cyc(input vec_t v);
        @(posedge clk);
        #1;
        reset = v.r; opcode = v.op; funct = v.fn; zero = v.z;
        @(negedge clk);
        chk({v.nm, " ctl"}, {7'b0, act_word}, {7'b0, v.ew});
        chk({v.nm, " illegal"}, {31'b0, illegal}, {31'b0, v.ill});
        chk({v.nm, " count"}, instr_count, v.cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Random-stream model state
    int          mcount;
    logic        mill;

    initial begin
        logic [24:0] wf, wd, w_ma, w_wb, w_halt;
        wf     = cw(0, 1,1,0,0,0,0, 0, 0,0, 0,2,0,0,0,0);
        wd     = cw(1, 0,0,0,0,1,1, 0, 0,0, 0,3,0,0,0,0);
        w_ma   = cw(2, 0,0,0,0,0,0, 0, 0,0, 1,1,0,0,0,0);
        w_wb   = cw(7, 0,0,0,1,0,0, 0, 0,0, 0,0,0,0,0,1);
        w_halt = cw(15, 0,0,0,0,0,0, 0, 0,0, 0,0,0,0,0,0);

        reset = 1'b1;
        repeat (2) @(posedge clk);

        add("reset",     1, 'h00, 'h20, 0, cw(0, 0,0,0,0,0,0, 0,0,0, 0,0,0,0,0,0), 0, 0);
        add("add fetch", 0, 'h3F, 'h11, 1, wf, 0, 0);
        add("add dec",   0, 'h00, 'h20, 0, wd, 0, 0);
        add("add exec",  0, 'h00, 'h20, 0, cw(6, 0,0,0,0,0,0, 0,0,0, 1,0,0,0,0,0), 0, 0);
        add("add wb",    0, 'h00, 'h20, 0, w_wb, 0, 0);
        add("lw fetch",  0, 'h00, 'h00, 0, wf, 0, 1);
        add("lw dec",    0, 'h23, 'h15, 0, wd, 0, 1);
        add("lw addr",   0, 'h23, 'h15, 0, w_ma, 0, 1);
        add("lw rd",     0, 'h23, 'h15, 0, cw(3, 0,0,0,0,0,0, 1,0,0, 0,0,0,0,0,0), 0, 1);
        add("lw wb",     0, 'h23, 'h15, 0, cw(4, 0,0,0,1,0,0, 0,1,1, 0,0,0,0,0,1), 0, 1);
        add("slt fetch", 0, 'h00, 'h00, 0, wf, 0, 2);
        add("slt dec",   0, 'h00, 'h2A, 0, wd, 0, 2);
        add("slt exec",  0, 'h00, 'h2A, 0, cw(6, 0,0,0,0,0,0, 0,0,0, 1,0,0,3,0,0), 0, 2);
        add("slt wb",    0, 'h00, 'h2A, 0, w_wb, 0, 2);
        add("sub fetch", 0, 'h00, 'h00, 0, wf, 0, 3);
        add("sub dec",   0, 'h00, 'h22, 0, wd, 0, 3);
        add("sub exec",  0, 'h00, 'h22, 0, cw(6, 0,0,0,0,0,0, 0,0,0, 1,0,0,1,0,0), 0, 3);
        add("sub wb",    0, 'h00, 'h22, 0, w_wb, 0, 3);
        add("xori fetch",0, 'h00, 'h00, 0, wf, 0, 4);
        add("xori dec",  0, 'h0E, 'h3F, 0, wd, 0, 4);
        add("xori exec", 0, 'h0E, 'h3F, 0, cw(8, 0,0,0,0,0,0, 0,0,0, 1,1,1,2,0,0), 0, 4);
        add("xori wb",   0, 'h0E, 'h3F, 0, cw(9, 0,0,0,1,0,0, 0,1,0, 0,0,0,0,0,1), 0, 4);
        add("addi fetch",0, 'h00, 'h00, 0, wf, 0, 5);
        add("addi dec",  0, 'h08, 'h01, 0, wd, 0, 5);
        add("addi exec", 0, 'h08, 'h01, 0, cw(8, 0,0,0,0,0,0, 0,0,0, 1,1,0,0,0,0), 0, 5);
        add("addi wb",   0, 'h08, 'h01, 0, cw(9, 0,0,0,1,0,0, 0,1,0, 0,0,0,0,0,1), 0, 5);
        add("beq1 fetch",0, 'h00, 'h00, 0, wf, 0, 6);
        add("beq1 dec",  0, 'h04, 'h00, 1, wd, 0, 6);
        add("beq1 br",   0, 'h04, 'h00, 1, cw(10, 1,0,0,0,0,0, 0,0,0, 1,0,0,1,1,1), 0, 6);
        add("beq0 fetch",0, 'h00, 'h00, 1, wf, 0, 7);
        add("beq0 dec",  0, 'h04, 'h00, 0, wd, 0, 7);
        add("beq0 br",   0, 'h04, 'h00, 0, cw(10, 0,0,0,0,0,0, 0,0,0, 1,0,0,1,1,1), 0, 7);
        add("bne1 fetch",0, 'h00, 'h00, 0, wf, 0, 8);
        add("bne1 dec",  0, 'h05, 'h00, 1, wd, 0, 8);
        add("bne1 br",   0, 'h05, 'h00, 1, cw(10, 0,0,0,0,0,0, 0,0,0, 1,0,0,1,1,1), 0, 8);
        add("bne0 fetch",0, 'h00, 'h00, 0, wf, 0, 9);
        add("bne0 dec",  0, 'h05, 'h00, 0, wd, 0, 9);
        add("bne0 br",   0, 'h05, 'h00, 0, cw(10, 1,0,0,0,0,0, 0,0,0, 1,0,0,1,1,1), 0, 9);
        add("j fetch",   0, 'h00, 'h00, 0, wf, 0, 10);
        add("j dec",     0, 'h02, 'h00, 0, wd, 0, 10);
        add("j jump",    0, 'h02, 'h00, 0, cw(11, 1,0,0,0,0,0, 0,0,0, 0,0,0,0,2,1), 0, 10);
        add("jal fetch", 0, 'h00, 'h00, 0, wf, 0, 11);
        add("jal dec",   0, 'h03, 'h00, 0, wd, 0, 11);
        add("jal jal",   0, 'h03, 'h00, 0, cw(12, 1,0,0,1,0,0, 0,2,2, 0,0,0,0,2,1), 0, 11);
        add("jr fetch",  0, 'h00, 'h00, 0, wf, 0, 12);
        add("jr dec",    0, 'h00, 'h08, 0, wd, 0, 12);
        add("jr jr",     0, 'h00, 'h08, 0, cw(13, 1,0,0,0,0,0, 0,0,0, 0,0,0,0,3,1), 0, 12);
        add("sw fetch",  0, 'h00, 'h00, 0, wf, 0, 13);
        add("sw dec",    0, 'h2B, 'h04, 0, wd, 0, 13);
        add("sw addr",   0, 'h2B, 'h04, 0, w_ma, 0, 13);
        add("sw wr",     0, 'h2B, 'h04, 0, cw(5, 0,0,1,0,0,0, 1,0,0, 0,0,0,0,0,1), 0, 13);
        add("swr fetch", 0, 'h00, 'h00, 0, wf, 0, 14);
        add("swr dec",   0, 'h2B, 'h04, 0, wd, 0, 14);
        add("swr addr",  0, 'h2B, 'h04, 0, w_ma, 0, 14);
        add("swr reset", 1, 'h2B, 'h04, 0, cw(5, 0,0,0,0,0,0, 0,0,0, 0,0,0,0,0,0), 0, 14);
        add("post rst",  0, 'h00, 'h20, 0, wf, 0, 0);
        add("add2 dec",  0, 'h00, 'h20, 0, wd, 0, 0);
        add("add2 exec", 0, 'h00, 'h20, 0, cw(6, 0,0,0,0,0,0, 0,0,0, 1,0,0,0,0,0), 0, 0);
        add("add2 wb",   0, 'h00, 'h20, 0, w_wb, 0, 0);
        add("ill fetch", 0, 'h00, 'h00, 0, wf, 0, 1);

        for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);

        // Unsupported opcode: DECODE still looks normal, then HALT absorbs.
        begin
            vec_t v;
            v.nm = "ill dec"; v.r = 1'b0; v.op = 6'h3F; v.fn = 6'h00; v.z = 1'b0;
            v.ew = wd; v.ill = 1'b0; v.cnt = 32'd1;
            cyc(v);
            for (int k = 0; k < 10; k++) begin
                v.nm = $sformatf("halt %0d", k);
                v.op = 6'($urandom); v.fn = 6'($urandom); v.z = 1'($urandom);
                v.ew = w_halt; v.ill = 1'b1; v.cnt = 32'd1;
                cyc(v);
            end
            v.nm = "halt reset"; v.r = 1'b1; v.ew = w_halt; v.ill = 1'b1; v.cnt = 32'd1;
            cyc(v);
            v.nm = "halt exit"; v.r = 1'b0; v.ew = wf; v.ill = 1'b0; v.cnt = 32'd0;
            cyc(v);
        end

        // Randomized instruction stream; the next cycle is DECODE of a new
        // instruction, so re-enter at FETCH with one reset cycle first.
        @(posedge clk); #1; reset = 1'b1;
        mcount = 0;
        mill   = 1'b0;
        for (int n = 0; n < 400; n++) begin
            int         kind;
            logic [5:0] op, fn;
            int         path[$];
            int         rs_at;
            logic       aborted;
            kind = $urandom_range(0, 11);
            if ($urandom_range(0, 29) == 0) kind = 12;
            fn = 6'($urandom);
            case (kind)
                0:  begin op = 6'h00; fn = 6'h20; path = '{0, 1, 6, 7}; end
                1:  begin op = 6'h00; fn = 6'h22; path = '{0, 1, 6, 7}; end
                2:  begin op = 6'h00; fn = 6'h2A; path = '{0, 1, 6, 7}; end
                3:  begin op = 6'h00; fn = 6'h08; path = '{0, 1, 13}; end
                4:  begin op = 6'h23; path = '{0, 1, 2, 3, 4}; end
                5:  begin op = 6'h2B; path = '{0, 1, 2, 5}; end
                6:  begin op = 6'h08; path = '{0, 1, 8, 9}; end
                7:  begin op = 6'h0E; path = '{0, 1, 8, 9}; end
                8:  begin op = 6'h04; path = '{0, 1, 10}; end
                9:  begin op = 6'h05; path = '{0, 1, 10}; end
                10: begin op = 6'h02; path = '{0, 1, 11}; end
                11: begin op = 6'h03; path = '{0, 1, 12}; end
                default: begin
                    case ($urandom_range(0, 2))
                        0:       begin op = 6'h3F; end
                        1:       begin op = 6'h00; fn = 6'h21; end
                        default: begin op = 6'h10; end
                    endcase
                    path = '{0, 1};
                end
            endcase
            rs_at   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, path.size() - 1)) : -1;
            aborted = 1'b0;
            for (int i = 0; i < path.size(); i++) begin
                logic       rr, z, last, e_pc, e_reg;
                logic [8:0] e;
                rr = (i == rs_at);
                z  = 1'($urandom);
                @(posedge clk);
                #1;
                reset = rr;
                zero  = z;
                if (i == 0) begin
                    opcode = 6'($urandom);
                    funct  = 6'($urandom);
                end else begin
                    opcode = op;
                    funct  = fn;
                end
                @(negedge clk);
                last  = (i == path.size() - 1) && (kind != 12);
                e_reg = last && (kind <= 2 || kind == 4 || kind == 6 || kind == 7 || kind == 11);
                e_pc  = (i == 0) || (last && (kind == 3 || kind == 10 || kind == 11)) ||
                        (last && kind == 8 && z) || (last && kind == 9 && !z);
                if (rr) e = {4'(path[i]), 5'b0};
                else    e = {4'(path[i]), last, e_pc, (i == 0), last && (kind == 5), e_reg};
                chk($sformatf("rnd%0d.%0d fx", n, i), {23'b0, act_fx}, {23'b0, e});
                chk($sformatf("rnd%0d.%0d count", n, i), instr_count, 32'(mcount));
                chk($sformatf("rnd%0d.%0d illegal", n, i), {31'b0, illegal}, {31'b0, mill});
                if (rr) begin
                    mcount  = 0;
                    mill    = 1'b0;
                    aborted = 1'b1;
                    break;
                end
                if (last) mcount++;
            end
            if (kind == 12 && !aborted) begin
                mill = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk);
                    #1;
                    reset  = (k == 3);
                    opcode = 6'($urandom);
                    funct  = 6'($urandom);
                    zero   = 1'($urandom);
                    @(negedge clk);
                    chk($sformatf("rnd%0d halt%0d fx", n, k), {23'b0, act_fx}, {23'b0, 4'd15, 5'b0});
                    chk($sformatf("rnd%0d halt%0d illegal", n, k), {31'b0, illegal}, {31'b0, mill});
                    chk($sformatf("rnd%0d halt%0d count", n, k), instr_count, 32'(mcount));
                end
                mcount = 0;
                mill   = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/multicycle_fsm.md
MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on rising clk.
REQ-004 opcode  in  6  instruction bits [31:26], driven from the held IR.
REQ-005 funct  in  6  instruction bits [5:0], driven from the held IR.
REQ-006 zero  in  1  ALU zero flag, current cycle.
REQ-007 pc_we, ir_we, mem_we, reg_we, a_we, b_we  out  1 each  write enables for the PC, IR, memory, regfile, A and B registers.
REQ-008 mem_in  out  1  memory address select: 0=PC, 1=ALU result register.
REQ-009 reg_dst  out  2  write-register select: 0=rd, 1=rt, 2=r31.
REQ-010 reg_in  out  2  write-data select: 0=ALU result register, 1=MDR, 2=PC.
REQ-011 alu_src_a  out  1  0=PC, 1=A register.
REQ-012 alu_src_b  out  2  0=B register, 1=extended imm16, 2=constant 4, 3=sign-extended imm16<<2.
REQ-013 zext  out  1  1=zero-extend imm16, 0=sign-extend.
REQ-014 alu_op  out  3  0=ADD, 1=SUB, 2=XOR, 3=SLT.
REQ-015 pc_src  out  2  0=ALU output, 1=ALU result register, 2=jump concat {PC[31:28],addr26,00}, 3=A register.
REQ-016 state  out  4  current state code (debug).
REQ-017 instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
REQ-018 illegal  out  1  sticky; set on unsupported opcode/funct.
REQ-019 instr_count  out  32  count of retired instructions.

Function
REQ-020 States and codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11, JAL=12, JR=13, HALT=15.
REQ-021 Every output not listed for a state SHALL be 0.
REQ-022 FETCH: mem_in=0, ir_we=1, alu_src_a=0, alu_src_b=2, alu_op=ADD, pc_src=0, pc_we=1; next is DECODE.
REQ-023 DECODE: a_we=1, b_we=1, alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALU result register); next state by opcode.
REQ-024 Decode map: 0x00 with funct 0x20/0x22/0x2A->EXEC_R; 0x00 with funct 0x08->JR; 0x23/0x2B->MEM_ADDR; 0x08/0x0E->EXEC_I; 0x04/0x05->BRANCH; 0x02->JUMP; 0x03->JAL; all others->HALT with illegal set.
REQ-025 EXEC_R: alu_src_a=1, alu_src_b=0, alu_op ADD/SUB/SLT for funct 0x20/0x22/0x2A; next R_WB.
REQ-026 R_WB: reg_we=1, reg_dst=0, reg_in=0, instr_done=1; next FETCH.
REQ-027 EXEC_I: alu_src_a=1, alu_src_b=1; ADDI: alu_op=ADD, zext=0; XORI: alu_op=XOR, zext=1; next I_WB.
REQ-028 I_WB: reg_we=1, reg_dst=1, reg_in=0, instr_done=1; next FETCH.
REQ-029 MEM_ADDR: alu_src_a=1, alu_src_b=1, zext=0, alu_op=ADD; LW->MEM_RD, SW->MEM_WR.
REQ-030 MEM_RD: mem_in=1; next MEM_WB. MEM_WB: reg_we=1, reg_dst=1, reg_in=1, instr_done=1; next FETCH.
REQ-031 MEM_WR: mem_in=1, mem_we=1, instr_done=1; next FETCH.
REQ-032 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1, pc_we=zero for 0x04, ~zero for 0x05 (combinational in zero); instr_done=1; next FETCH.
REQ-033 JUMP: pc_src=2, pc_we=1, instr_done=1. JAL: same plus reg_we=1, reg_dst=2, reg_in=2 (PC already +4). JR: pc_src=3, pc_we=1, instr_done=1. All next FETCH.
REQ-034 HALT: absorbing until reset; all enables 0; instr_count frozen.
REQ-035 Latencies (cycles): LW 5; SW, R-type, ADDI, XORI 4; BEQ, BNE, J, JAL, JR 3.
REQ-036 instr_count SHALL increment by 1 on each cycle with instr_done=1, wrapping 0xFFFFFFFF->0.
REQ-037 opcode/funct are sampled only in DECODE and states after it; their values during FETCH are ignored.

Reset
REQ-038 reset high on a rising edge SHALL force state=FETCH, illegal=0, instr_count=0, regardless of current state (including mid-instruction and HALT).
REQ-039 While reset is high, every write enable and instr_done SHALL be driven 0; selects 0.
REQ-040 First cycle after reset deasserts SHALL be FETCH with its REQ-022 outputs.

Verification
REQ-041 ADD (opcode 0, funct 0x20) after reset -> states 0,1,6,7,0; reg_we=1 only in R_WB with reg_dst=0; instr_count=1.
REQ-042 LW (0x23) -> states 0,1,2,3,4; mem_in=1 in 3; reg_we with reg_in=1, reg_dst=1 in 4; 5 cycles.
REQ-043 BEQ with zero=1 -> pc_we=1, pc_src=1 in BRANCH; BNE with zero=1 -> pc_we=0; both return to FETCH.
REQ-044 JAL (0x03) -> JAL state drives reg_dst=2, reg_in=2, reg_we=1, pc_src=2, pc_we=1.
REQ-045 opcode 0x3F -> HALT, illegal=1, no further enables for 10 cycles; reset -> FETCH, illegal=0, instr_count=0.
REQ-046 reset asserted in MEM_WR cycle -> mem_we=0 that cycle; next cycle FETCH; instr_count=0.
